// File: rtl/reg_file_busywait_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : reg_file_busywait_pkg
// Description : Shared widths and write-back FSM encoding for the register file
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
package reg_file_busywait_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int NREGS  = 1 << ADDR_W;

  // Write-back FSM: PEND holds a write captured while the data cache stalls
  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_PEND = 1'b1
  } wb_state_t;

endpackage
`default_nettype wire

// File: rtl/reg_file_busywait_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : reg_file_busywait_if
// Description : Read/write bus between the control unit and the register file
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
interface reg_file_busywait_if;
  import reg_file_busywait_pkg::*;

  logic [DATA_W-1:0] IN;
  logic [ADDR_W-1:0] INADDRESS;
  logic              WRITE;
  logic              BUSYWAIT;
  logic [ADDR_W-1:0] OUT1ADDRESS;
  logic [ADDR_W-1:0] OUT2ADDRESS;
  logic [DATA_W-1:0] OUT1;
  logic [DATA_W-1:0] OUT2;
  logic              WB_PENDING;

  // Control unit side
  modport master (
    output IN, INADDRESS, WRITE, BUSYWAIT, OUT1ADDRESS, OUT2ADDRESS,
    input  OUT1, OUT2, WB_PENDING
  );

  // Register file side
  modport slave (
    input  IN, INADDRESS, WRITE, BUSYWAIT, OUT1ADDRESS, OUT2ADDRESS,
    output OUT1, OUT2, WB_PENDING
  );

endinterface
`default_nettype wire

// File: rtl/reg_file_busywait.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : reg_file_busywait
// Description : 8x8 register file, two combinational read ports, one clocked
//               write port whose write-back is deferred across cache stalls
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module reg_file_busywait
  import reg_file_busywait_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET_N,
  reg_file_busywait_if.slave bus
);

  logic [DATA_W-1:0] r_regs [0:NREGS-1];
  wb_state_t         r_state;
  logic [ADDR_W-1:0] r_pend_addr;
  logic              r_wb_pending;

  // Write-back FSM and register array: at most one register write per edge.
  // While stalled the captured index is frozen; the data arrives on release,
  // so the commit uses IN on the release edge regardless of WRITE.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state      <= WB_IDLE;
      r_pend_addr  <= '0;
      r_wb_pending <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      case (r_state)
        WB_IDLE: begin
          if (bus.WRITE) begin
            if (bus.BUSYWAIT) begin
              r_pend_addr  <= bus.INADDRESS;
              r_wb_pending <= 1'b1;
              r_state      <= WB_PEND;
            end else begin
              r_regs[bus.INADDRESS] <= bus.IN;
            end
          end
        end
        WB_PEND: begin
          if (!bus.BUSYWAIT) begin
            r_regs[r_pend_addr] <= bus.IN;
            r_wb_pending        <= 1'b0;
            r_state             <= WB_IDLE;
          end
        end
        default: r_state <= WB_IDLE;
      endcase
    end
  end

  // Combinational read ports; no same-edge write bypass
  assign bus.OUT1       = r_regs[bus.OUT1ADDRESS];
  assign bus.OUT2       = r_regs[bus.OUT2ADDRESS];
  assign bus.WB_PENDING = r_wb_pending;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_busywait.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : tb_reg_file_busywait
// Description : Scoreboard bench for reg_file_busywait
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_reg_file_busywait;

  typedef struct {
    string      name;
    logic [7:0] e1;
    logic [7:0] e2;
    logic       ewb;
    logic       chk_neg;
    logic [7:0] eneg;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  exp_t sb_q[$];
  event ev_chk;

  reg_file_busywait_if bus();

  reg_file_busywait dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish within 50000 time units");
    $fatal(1, "timeout");
  end

  task automatic cmp8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  // Monitor: each time the stimulus presents a read, pop the expectation
  always begin
    exp_t e;
    @(ev_chk);
    if (sb_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL sb_underflow: got a read with no expectation queued, expected one");
    end else begin
      e = sb_q.pop_front();
      cmp8({e.name, ".OUT1"}, bus.OUT1, e.e1);
      cmp8({e.name, ".OUT2"}, bus.OUT2, e.e2);
      cmp8({e.name, ".WB_PENDING"}, {7'd0, bus.WB_PENDING}, {7'd0, e.ewb});
      if (e.chk_neg) begin
        logic [7:0] neg;
        neg = ~bus.OUT2 + 8'd1;
        cmp8({e.name, ".NEG"}, neg, e.eneg);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [2:0] a1, input logic [2:0] a2,
                       input logic [7:0] e1, input logic [7:0] e2, input logic ewb,
                       input logic chk_neg = 1'b0, input logic [7:0] eneg = 8'h00);
    exp_t e;
    bus.OUT1ADDRESS = a1;
    bus.OUT2ADDRESS = a2;
    e.name = name; e.e1 = e1; e.e2 = e2; e.ewb = ewb; e.chk_neg = chk_neg; e.eneg = eneg;
    sb_q.push_back(e);
    #1;
    -> ev_chk;
    #1;
  endtask

  task automatic drive(input logic wr, input logic bw, input logic [2:0] a, input logic [7:0] d);
    bus.WRITE     = wr;
    bus.BUSYWAIT  = bw;
    bus.INADDRESS = a;
    bus.IN        = d;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 8'h00);
    bus.OUT1ADDRESS = 3'd0;
    bus.OUT2ADDRESS = 3'd0;
    tick(); tick();
    rst_n = 1'b1;
    check("reset", 3'd0, 3'd7, 8'h00, 8'h00, 1'b0);

    // Basic write/read
    drive(1'b1, 1'b0, 3'd3, 8'h5A);
    tick();
    drive(1'b0, 1'b0, 3'd0, 8'h00);
    check("basic_wr", 3'd3, 3'd3, 8'h5A, 8'h5A, 1'b0);

    // BUSYWAIT with no write in IDLE: nothing happens
    drive(1'b0, 1'b1, 3'd5, 8'hEE);
    tick();
    check("busy_nowr", 3'd5, 3'd3, 8'h00, 8'h5A, 1'b0);

    // Stalled write to r5, released with WRITE low
    drive(1'b1, 1'b1, 3'd5, 8'h99);
    tick();
    check("stall_e1", 3'd5, 3'd3, 8'h00, 8'h5A, 1'b1);
    tick(); tick();
    check("stall_e3", 3'd5, 3'd3, 8'h00, 8'h5A, 1'b1);
    drive(1'b0, 1'b0, 3'd0, 8'hC3);
    tick();
    check("stall_rel", 3'd5, 3'd3, 8'hC3, 8'h5A, 1'b0);

    // Frozen pend_addr: capture 2, move INADDRESS to 6 while stalled
    drive(1'b1, 1'b1, 3'd2, 8'h77);
    tick();
    drive(1'b1, 1'b1, 3'd6, 8'h66);
    tick(); tick();
    check("frozen_hold", 3'd2, 3'd6, 8'h00, 8'h00, 1'b1);
    drive(1'b0, 1'b0, 3'd6, 8'h11);
    tick();
    check("frozen_rel", 3'd2, 3'd6, 8'h11, 8'h00, 1'b0);

    // Reset mid-stall discards the pending write and clears everything
    drive(1'b1, 1'b1, 3'd4, 8'h44);
    tick();
    check("rst_pend", 3'd4, 3'd3, 8'h00, 8'h5A, 1'b1);
    bus.WRITE = 1'b0;
    rst_n = 1'b0;
    check("rst_async", 3'd3, 3'd5, 8'h00, 8'h00, 1'b0);
    rst_n = 1'b1;
    bus.BUSYWAIT = 1'b0;
    tick();
    check("rst_nocommit", 3'd4, 3'd2, 8'h00, 8'h00, 1'b0);

    // Dual read and negation path
    drive(1'b1, 1'b0, 3'd1, 8'h07);
    tick();
    drive(1'b1, 1'b0, 3'd2, 8'h03);
    tick();
    drive(1'b0, 1'b0, 3'd0, 8'h00);
    check("dual_neg", 3'd1, 3'd2, 8'h07, 8'h03, 1'b0, 1'b1, 8'hFD);

    // Index 0 and 7 are ordinary registers
    drive(1'b1, 1'b0, 3'd0, 8'hA5);
    tick();
    drive(1'b1, 1'b0, 3'd7, 8'h80);
    tick();
    drive(1'b0, 1'b0, 3'd0, 8'h00);
    check("idx_0_7", 3'd7, 3'd0, 8'h80, 8'hA5, 1'b0, 1'b1, 8'h5B);

    // Release with WRITE still high: exactly one commit, to the pending index
    drive(1'b1, 1'b1, 3'd6, 8'h01);
    tick();
    drive(1'b1, 1'b0, 3'd6, 8'h3C);
    tick();
    drive(1'b0, 1'b0, 3'd0, 8'h00);
    check("rel_wr_hi", 3'd6, 3'd1, 8'h3C, 8'h07, 1'b0);

    #5;
    n_chk++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d expectations left, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
